regfile_mp: RTL

- Parametrised multi-port register file for the pipelined MIPS core.
- Provides NUM_RD read ports and NUM_WR write ports, with same-cycle write-to-read bypass, an optional hardwired zero register and a per-register busy scoreboard.
- The scoreboard lets decode stall on outstanding multi-cycle writers (loads, mul/div).
- Sits between decode (reads, issue marks) and writeback (writes, busy clears).

---
 rtl/regfile_mp.sv | 101 ++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write-to-read bypass, optional hardwired
// zero register and a per-register busy scoreboard for long-latency producers.
module regfile_mp #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 32,
  parameter int                NUM_RD   = 2,
  parameter int                NUM_WR   = 2,
  parameter int                ZERO_REG = 1,
  parameter int                SP_IDX   = 29,
  parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(32'h80120002),
  parameter int                RA_IDX   = 31,
  parameter logic [DATA_W-1:0] RA_INIT  = DATA_W'(32'h77777777),
  localparam int               ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]        wr_clr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [DEPTH-1:0]         busy_vec
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;

  function automatic logic hardzero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Set wins over clear: loop order applies clears first, then the issue.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    busy_next = busy;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && wr_clr[w])
        busy_next[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (iss_en)
      busy_next[iss_addr] = 1'b1;
    if (ZERO_REG != 0)
      busy_next[0] = 1'b0;
  end

  // NOTE: the register array is reset to architectural values, so it cannot map to a RAM macro.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= DATA_W'(i);
      regs[SP_IDX] <= SP_INIT;
      regs[RA_IDX] <= RA_INIT;
      if (ZERO_REG != 0)
        regs[0] <= '0;
      busy <= '0;
    end else begin
      // NOTE: non-blocking updates; with several hits the last (highest-index) port wins.
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && !hardzero(wr_addr[w*ADDR_W +: ADDR_W]))
          regs[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
      end
      busy <= busy_next;
    end
  end

  assign busy_vec = busy;

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              clr_hit;
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a       = rd_addr[p*ADDR_W +: ADDR_W];
      d       = regs[a];
      clr_hit = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (!reset && wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == a) begin
          d = wr_data[w*DATA_W +: DATA_W];
          if (wr_clr[w])
            clr_hit = 1'b1;
        end
      end
      // A same-cycle clear is bypassed unless a new producer claims the register.
      if (hardzero(a)) begin
        rd_data[p*DATA_W +: DATA_W] = '0;
        rd_busy[p]                  = 1'b0;
      end else begin
        rd_data[p*DATA_W +: DATA_W] = d;
        rd_busy[p]                  = busy[a] && !(clr_hit && !(iss_en && iss_addr == a));
      end
    end
  end

endmodule
